cbus_mem_responder: RTL and testbench

- Responder end of the cache bus: accepts `cbus_req_t` bursts from a cache or arbiter and answers with `cbus_resp_t` beats.
- Backed by an on-chip 64-bit-word memory.
- Used as the simulation/FPGA main-memory model behind the data/instruction caches, and as the golden peer for verifying cache refill and writeback logic.
- Supports FIXED, INCR and WRAP bursts, byte strobes, and configurable first-beat read latency.

---
 rtl/cbus_mem_responder_pkg.sv | 81 ++++++++
 rtl/cbus_mem_responder_if.sv | 11 +
 rtl/cbus_mem_responder_mem_array.sv | 32 +++
 rtl/cbus_mem_responder.sv | 152 +++++++++++++++
 tb/tb_cbus_mem_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_mem_responder_pkg.sv
// Cache-bus type definitions and helpers shared by the memory responder and
// cache-side masters: request/response beats, burst encodings, the responder
// FSM state type and the common beat-address advance function.
package cbus_mem_responder_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    // Bytes per beat, encoded as log2.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Burst length minus one.
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED    = 2'd0,
        AXI_BURST_INCR     = 2'd1,
        AXI_BURST_WRAP     = 2'd2,
        AXI_BURST_RESERVED = 2'd3
    } axi_burst_type_t;

    // 151-bit request, held stable by the master until the last beat.
    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    // 66-bit beat response.
    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RWAIT = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } cbus_resp_state_t;

    // Address of the beat following the one at addr. RESERVED behaves as INCR.
    function automatic addr_t cbus_next_addr(
        input addr_t           addr,
        input msize_t          size,
        input mlen_t           len,
        input axi_burst_type_t burst
    );
        addr_t step;
        addr_t mask;
        addr_t next;
        step = 64'd1 << size;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            AXI_BURST_FIXED: next = addr;
            AXI_BURST_WRAP:  next = (addr & ~mask) | ((addr + step) & mask);
            default:         next = addr + step;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/cbus_mem_responder_if.sv
// Cache-bus link: one request bundle from the master, one response bundle back.
interface cbus_mem_responder_if;
    import cbus_mem_responder_pkg::*;

    cbus_req_t  creq;
    cbus_resp_t cresp;

    modport master (output creq, input cresp);
    modport slave  (input creq, output cresp);

endinterface

// File: rtl/cbus_mem_responder_mem_array.sv
// Word-wide backing store: one asynchronous read port and one synchronous
// byte-strobed write port.
module cbus_mem_array #(
    parameter int unsigned MEM_WORDS = 65536,
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [63:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_strobe_i,
    input  logic [63:0]      wr_data_i
);

    logic [63:0] mem_q [MEM_WORDS];

    assign rd_data_o = mem_q[rd_idx_i];

    // Merge the enabled bytes of the write data into the addressed word.
    // NOTE: the array has no reset; contents survive reset and clearing it would block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_strobe_i[b]) begin
                    mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cbus_mem_responder.sv
// Cache-bus memory responder: accepts FIXED/INCR/WRAP bursts and answers with
// registered beats from an on-chip word array, with a configurable read latency.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 65536,
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    cbus_mem_responder_if.slave  cbus
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [63:0] SPAN  = 64'(MEM_WORDS) << 3;

    cbus_resp_state_t state_q, state_d;
    addr_t            addr_q, addr_d;
    msize_t           size_q, size_d;
    mlen_t            len_q, len_d;
    axi_burst_type_t  burst_q, burst_d;
    logic [7:0]       beat_q, beat_d;
    logic [3:0]       wait_q, wait_d;
    cbus_resp_t       cresp_q, cresp_d;

    logic [63:0]      rd_off, wr_off;
    logic             rd_in_range, wr_in_range;
    logic [63:0]      rd_data;
    logic             mem_we;

    // Read port follows the next beat address so the registered response
    // carries the word for the beat it announces.
    assign rd_off      = addr_d - BASE_ADDR;
    assign rd_in_range = rd_off < SPAN;
    // Write port uses the beat currently being presented.
    assign wr_off      = addr_q - BASE_ADDR;
    assign wr_in_range = wr_off < SPAN;

    cbus_mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk         (clk),
        .rd_idx_i    (rd_off[3 +: IDX_W]),
        .rd_data_o   (rd_data),
        .we_i        (mem_we),
        .wr_idx_i    (wr_off[3 +: IDX_W]),
        .wr_strobe_i (cbus.creq.strobe),
        .wr_data_i   (cbus.creq.data)
    );

    assign cbus.cresp = cresp_q;

    // State register: FSM, burst context and the registered response.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= MSIZE1;
            len_q   <= MLEN1;
            burst_q <= AXI_BURST_FIXED;
            beat_q  <= '0;
            wait_q  <= '0;
            cresp_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            cresp_q <= cresp_d;
        end
    end

    // Next-state logic: acceptance, latency countdown, beat sequencing, abort.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        len_d   = len_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (cbus.creq.valid) begin
                    addr_d  = cbus.creq.addr;
                    size_d  = cbus.creq.size;
                    len_d   = cbus.creq.len;
                    burst_d = cbus.creq.burst;
                    beat_d  = '0;
                    if (cbus.creq.is_write) begin
                        state_d = WRITE;
                    end else if (READ_LATENCY == 0) begin
                        state_d = READ;
                    end else begin
                        state_d = RWAIT;
                        wait_d  = 4'(READ_LATENCY);
                    end
                end
            end
            RWAIT: begin
                if (!cbus.creq.valid) begin
                    state_d = IDLE;
                end else if (wait_q <= 4'd1) begin
                    state_d = READ;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            READ, WRITE: begin
                if (!cbus.creq.valid) begin
                    state_d = IDLE;
                end else if (beat_q == len_q) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 8'd1;
                    addr_d = cbus_next_addr(addr_q, size_q, len_q, burst_q);
                end
            end
            DONE: begin
                // A valid still held from the finished burst is never re-accepted.
                if (!cbus.creq.valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next response beat and the memory write strobe.
    always_comb begin
        cresp_d = '0;
        mem_we  = 1'b0;
        if (state_d == READ || state_d == WRITE) begin
            cresp_d.ready = 1'b1;
            cresp_d.last  = (beat_d == len_d);
            if (state_d == READ && rd_in_range) begin
                cresp_d.data = rd_data;
            end
        end
        // A write beat commits only while the master still holds valid.
        if (state_q == WRITE && cbus.creq.valid && wr_in_range && !reset) begin
            mem_we = 1'b1;
        end
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for the cache-bus memory responder: a driver issues bursts and
// pushes expected beats; a negedge monitor pops and compares every ready beat.
`timescale 1ns/1ps
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    localparam int unsigned RL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_mem_responder_if bus ();

    cbus_mem_responder #(
        .MEM_WORDS    (65536),
        .BASE_ADDR    (64'h0000_0000_8000_0000),
        .READ_LATENCY (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cbus  (bus)
    );

    typedef struct {
        logic        last;
        logic [63:0] data;
        bit          chk_data;
        int          rel;
    } exp_beat_t;

    exp_beat_t   sb[$];
    int          vectors   = 0;
    int          fails     = 0;
    int          cycle_cnt = 0;
    int          txn_start = 0;
    logic [63:0] wdata    [16];
    logic [7:0]  wstrb    [16];
    logic [63:0] exp_data [16];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Monitor: every ready beat must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_beat_t e;
        if (bus.cresp.ready) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got data=%h last=%b at rel cycle %0d, expected no beat",
                         bus.cresp.data, bus.cresp.last, cycle_cnt - txn_start);
            end else begin
                e = sb.pop_front();
                if (bus.cresp.last !== e.last ||
                    (e.chk_data && bus.cresp.data !== e.data) ||
                    (e.rel >= 0 && (cycle_cnt - txn_start) != e.rel)) begin
                    fails++;
                    $display("FAIL beat: got data=%h last=%b rel=%0d, expected data=%h(chk=%0d) last=%b rel=%0d",
                             bus.cresp.data, bus.cresp.last, cycle_cnt - txn_start,
                             e.data, e.chk_data, e.last, e.rel);
                end
            end
        end
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue n beats from exp_data; last flags the final beat of a burst of len1.
    task automatic expect_seq(input int n, input int len1, input int rel0, input bit chk);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{last: (i == len1 - 1), data: exp_data[i], chk_data: chk, rel: rel0 + i});
        end
    endtask

    // Run one burst. stop_after > 0 ends it early: by dropping valid, or by reset.
    task automatic drive(input logic wr, input logic [63:0] addr, input msize_t size,
                         input mlen_t len, input axi_burst_type_t burst,
                         input int stop_after, input bit use_reset, input int hold);
        int beats;
        int budget;
        bit done;
        bit stopped;
        beats = 0; budget = 0; done = 0; stopped = 0;
        @(negedge clk);
        txn_start         = cycle_cnt;
        bus.creq.is_write = wr;
        bus.creq.addr     = addr;
        bus.creq.size     = size;
        bus.creq.len      = len;
        bus.creq.burst    = burst;
        bus.creq.data     = wr ? wdata[0] : 64'd0;
        bus.creq.strobe   = wr ? wstrb[0] : 8'd0;
        bus.creq.valid    = 1'b1;
        while (!done) begin
            @(negedge clk);
            budget++;
            if (bus.cresp.ready) begin
                // Data for the beat presented now; it is written at the next edge.
                if (wr) begin
                    bus.creq.data   = wdata[beats];
                    bus.creq.strobe = wstrb[beats];
                end
                beats++;
                if (stop_after != 0 && beats == stop_after) begin
                    done    = 1;
                    stopped = 1;
                    if (use_reset) begin
                        reset          = 1'b1;
                        bus.creq.valid = 1'b0;
                    end else begin
                        @(posedge clk);
                        #1 bus.creq.valid = 1'b0;
                    end
                end else if (bus.cresp.last) begin
                    done = 1;
                end
            end
            if (!done && budget > 64) begin
                vectors++;
                fails++;
                $display("FAIL burst_timeout: got %0d beats, expected %0d", beats, int'(len) + 1);
                done = 1;
            end
        end
        if (stopped && use_reset) begin
            @(negedge clk);
            check("reset_clears_cresp", bus.cresp, 66'd0);
            reset = 1'b0;
            @(negedge clk);
        end else if (stopped) begin
            repeat (3) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
            bus.creq.valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.creq = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cresp", bus.cresp, 66'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single write then single read; valid held in DONE must not retrigger.
        wdata[0] = 64'hDEAD_BEEF_0123_4567; wstrb[0] = 8'hFF;
        exp_data[0] = 64'd0;
        expect_seq(1, 1, 1, 0);
        drive(1'b1, 64'h8000_0000, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        exp_data[0] = 64'hDEAD_BEEF_0123_4567;
        expect_seq(1, 1, RL + 1, 1);
        drive(1'b0, 64'h8000_0000, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 4);

        // INCR write of 1..4 and readback.
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'(i + 1); wstrb[i] = 8'hFF;
        end
        expect_seq(4, 4, 1, 0);
        drive(1'b1, 64'h8000_0100, MSIZE8, MLEN4, AXI_BURST_INCR, 0, 0, 1);
        exp_data[0] = 64'd1; exp_data[1] = 64'd2; exp_data[2] = 64'd3; exp_data[3] = 64'd4;
        expect_seq(4, 4, RL + 1, 1);
        drive(1'b0, 64'h8000_0100, MSIZE8, MLEN4, AXI_BURST_INCR, 0, 0, 1);

        // FIXED burst repeats one word; 4-byte INCR steps two beats per word.
        exp_data[0] = 64'd2; exp_data[1] = 64'd2; exp_data[2] = 64'd2; exp_data[3] = 64'd2;
        expect_seq(4, 4, RL + 1, 1);
        drive(1'b0, 64'h8000_0108, MSIZE8, MLEN4, AXI_BURST_FIXED, 0, 0, 1);
        exp_data[0] = 64'd1; exp_data[1] = 64'd1; exp_data[2] = 64'd2; exp_data[3] = 64'd2;
        expect_seq(4, 4, RL + 1, 1);
        drive(1'b0, 64'h8000_0100, MSIZE4, MLEN4, AXI_BURST_INCR, 0, 0, 1);

        // Words 0..7 hold their index; WRAP from word 5 wraps at the 64-byte line.
        for (int i = 0; i < 8; i++) begin
            wdata[i] = 64'(i); wstrb[i] = 8'hFF;
        end
        expect_seq(8, 8, 1, 0);
        drive(1'b1, 64'h8000_0000, MSIZE8, MLEN8, AXI_BURST_INCR, 0, 0, 1);
        exp_data[0] = 64'd5; exp_data[1] = 64'd6; exp_data[2] = 64'd7; exp_data[3] = 64'd0;
        exp_data[4] = 64'd1; exp_data[5] = 64'd2; exp_data[6] = 64'd3; exp_data[7] = 64'd4;
        expect_seq(8, 8, RL + 1, 1);
        drive(1'b0, 64'h8000_0028, MSIZE8, MLEN8, AXI_BURST_WRAP, 0, 0, 1);

        // Byte-strobe merge into an all-ones word.
        wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'hFF;
        expect_seq(1, 1, 1, 0);
        drive(1'b1, 64'h8000_0200, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        wdata[0] = 64'h0000_00CD_0000_0000; wstrb[0] = 8'b0001_0000;
        expect_seq(1, 1, 1, 0);
        drive(1'b1, 64'h8000_0200, MSIZE1, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        exp_data[0] = 64'hFFFF_FFCD_FFFF_FFFF;
        expect_seq(1, 1, RL + 1, 1);
        drive(1'b0, 64'h8000_0200, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);

        // Range edges: below base reads 0; one past the end is dropped (word 0 intact);
        // the last word is writable.
        exp_data[0] = 64'd0;
        expect_seq(1, 1, RL + 1, 1);
        drive(1'b0, 64'h7FFF_FFF8, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        wdata[0] = 64'h0000_0000_0000_0BAD; wstrb[0] = 8'hFF;
        expect_seq(1, 1, 1, 0);
        drive(1'b1, 64'h8008_0000, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        exp_data[0] = 64'd0;
        expect_seq(1, 1, RL + 1, 1);
        drive(1'b0, 64'h8008_0000, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        expect_seq(1, 1, RL + 1, 1);
        drive(1'b0, 64'h8000_0000, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        wdata[0] = 64'h1234_5678_9ABC_DEF0; wstrb[0] = 8'hFF;
        expect_seq(1, 1, 1, 0);
        drive(1'b1, 64'h8007_FFF8, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);
        exp_data[0] = 64'h1234_5678_9ABC_DEF0;
        expect_seq(1, 1, RL + 1, 1);
        drive(1'b0, 64'h8007_FFF8, MSIZE8, MLEN1, AXI_BURST_INCR, 0, 0, 1);

        // Abort: preload A-pattern, drop valid after 3 write beats of a B-pattern.
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 64'hA0 + 64'(i); wstrb[i] = 8'hFF;
        end
        expect_seq(16, 16, 1, 0);
        drive(1'b1, 64'h8000_0400, MSIZE8, MLEN16, AXI_BURST_INCR, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            wdata[i] = 64'hB0 + 64'(i); wstrb[i] = 8'hFF;
        end
        // The fourth beat was registered before valid fell; it is shown but not written.
        expect_seq(4, 16, 1, 0);
        drive(1'b1, 64'h8000_0400, MSIZE8, MLEN16, AXI_BURST_INCR, 3, 0, 0);
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = (i < 3) ? 64'hB0 + 64'(i) : 64'hA0 + 64'(i);
        end
        expect_seq(16, 16, RL + 1, 1);
        drive(1'b0, 64'h8000_0400, MSIZE8, MLEN16, AXI_BURST_INCR, 0, 0, 1);

        // Reset on the second beat of an 8-beat read, then a fresh full read.
        for (int i = 0; i < 8; i++) begin
            exp_data[i] = 64'(i);
        end
        expect_seq(2, 8, RL + 1, 1);
        drive(1'b0, 64'h8000_0000, MSIZE8, MLEN8, AXI_BURST_INCR, 2, 1, 0);
        expect_seq(8, 8, RL + 1, 1);
        drive(1'b0, 64'h8000_0000, MSIZE8, MLEN8, AXI_BURST_INCR, 0, 0, 1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 66'(sb.size()), 66'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
